dffram_dp: RTL
==============

# dffram_dp

Parametrised dual-port DFF RAM for mesh/vertex storage: port 0 read/write with byte enables, port 1 read-only. It adds a hardware clear sequencer that sweeps every word to a fill value after reset or on request. Port 1 has same-address write-through, so the subdivision datapath can read a freshly written vertex in the same cycle it is written. It replaces the fixed 512x32 single-port instance and drops simulation-only file dumps from the RTL.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDR_WIDTH, 9, address bits; depth = 2**ADDR_WIDTH.
- CLEAR_ON_RESET, 1, 1 = start a clear sweep when RST deasserts; 0 = memory contents undefined after reset.
- FILL_VALUE, 0, word written by the clear sweep (DATA_WIDTH bits).
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN0  in  1  port 0 enable.
- WE0  in  DATA_WIDTH/8  port 0 byte write enables; bit i covers Di0[8i+7:8i].
- A0  in  ADDR_WIDTH  port 0 address.
- Di0  in  DATA_WIDTH  port 0 write data.
- Do0  out  DATA_WIDTH  port 0 read data, registered.
- EN1  in  1  port 1 read enable.
- A1  in  ADDR_WIDTH  port 1 address.
- Do1  out  DATA_WIDTH  port 1 read data, registered.
- CLR  in  1  single-cycle request to start or restart a clear sweep.
- BUSY  out  1  high while the clear sweep runs; ports are ignored.

## Operation
- FSM states: IDLE and CLEAR. Clear counter width is ADDR_WIDTH+1.
- RST high: Do0=0, Do1=0, counter=0. State goes to CLEAR with BUSY=1 if CLEAR_ON_RESET=1; otherwise IDLE with BUSY=0.
- CLEAR: each cycle writes FILL_VALUE to word counter[ADDR_WIDTH-1:0], then increments the counter.
  - After writing word 2**ADDR_WIDTH-1, go to IDLE and deassert BUSY.
  - EN0, WE0, EN1 are ignored; no user write reaches memory; Do0 and Do1 are held at 0.
- IDLE, CLR=1: go to CLEAR with counter=0. Port accesses presented in that same cycle are still serviced.
- CLEAR, CLR=1: counter restarts at 0; the sweep is lengthened, never shortened.
- Port 0, EN0=1: Do0 <= mem[A0] (old data, read-first). Bytes with WE0[i]=1 are written from Di0.
- Port 0, EN0=0: Do0 <= 0 and no write.
- Port 1, EN1=1:
  - Do1 <= mem[A1].
  - If EN0=1, A0==A1 and any WE0 bit is set: each enabled byte lane of Do1 takes Di0's byte; the other lanes take mem[A1] (write-through merge).
- Port 1, EN1=0: Do1 <= 0.
- No write conflicts are possible: port 1 never writes and the sweep excludes user writes.

## Timing
- Read latency is 1 cycle on both ports: address at edge N, data valid after edge N+1.
- Write takes effect at edge N; a port 1 read at edge N+1 sees it. Same-edge visibility on port 1 is via the bypass only.
- Clear sweep takes exactly 2**ADDR_WIDTH cycles after RST falls or after the cycle CLR is sampled. BUSY falls in the cycle after the last fill write.
- Reset mid-sweep: the sweep restarts from word 0 (CLEAR_ON_RESET=1) or aborts with partial contents (CLEAR_ON_RESET=0).
- Address wrap is not needed: all addresses are in range.

## Structure
- Package dffram_pkg:
  - state enum {S_IDLE, S_CLEAR}.
  - localparam function for byte-lane count (DATA_WIDTH/8).
  - Elaboration check that DATA_WIDTH % 8 == 0.
- Sub-module dffram_clear_seq: FSM, counter, BUSY and fill address/write strobe.
- Top level: memory array, port muxing, bypass merge and output registers.

## Test plan
- Reset with CLEAR_ON_RESET=1 (DATA_WIDTH=32, ADDR_WIDTH=4, FILL_VALUE=32'hDEADBEEF) -> BUSY high for exactly 16 cycles after RST falls; then port 1 reads of all 16 addresses return 32'hDEADBEEF.
- Port 0 write A0=3, Di0=32'h11223344, WE0=4'b0101 onto 32'hDEADBEEF -> Do0 returns old 32'hDEADBEEF that cycle; a later read returns 32'hDE22BE44.
- Same-cycle port 0 write (A0=5, Di0=32'hAABBCCDD, WE0=4'b1100) and port 1 read A1=5 -> Do1=32'hAABBBEEF next cycle; port 1 read with A1=6 -> 32'hDEADBEEF.
- EN0=0, EN1=0 with stray WE0=4'hF -> Do0=Do1=0, memory unchanged.
- CLR pulse, second CLR 5 cycles later -> BUSY stays high 21 cycles total; user writes issued during BUSY are dropped (readback equals FILL_VALUE).
- RST asserted mid-sweep at word 7 -> outputs 0; the sweep restarts at word 0 and completes 16 cycles after RST falls.

Source files
------------

// File: rtl/dffram_pkg.sv
// Shared types and elaboration helpers for the dual-port DFF RAM.
package dffram_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  function automatic int unsigned lane_count(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic bit width_ok(input int unsigned dw);
    return (dw % 8) == 0;
  endfunction

endpackage

// File: rtl/dffram_clear_seq.sv
// Clear sequencer: sweeps every word address once, raising BUSY while it runs.
module dffram_clear_seq
  import dffram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_fill_addr,
  output logic                  o_fill_we
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH:0]   w_cnt_nxt;
  logic [ADDR_WIDTH:0]   w_cnt_inc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The extra counter bit flags that the last word has just been written.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cnt_inc   = r_cnt + CNT_ONE;
    unique case (r_state)
      S_IDLE: begin
        if (i_clr) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        if (i_clr) begin
          w_cnt_nxt = '0;
        end else if (w_cnt_inc[ADDR_WIDTH]) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy      = (r_state == S_CLEAR);
  assign o_fill_addr = r_cnt[ADDR_WIDTH-1:0];
  assign o_fill_we   = (r_state == S_CLEAR) && !i_rst;

endmodule

// File: rtl/dffram_dp.sv
// Dual-port DFF RAM: port 0 read/write with byte enables, port 1 read-only
// with same-address write-through, plus a hardware clear sweep.
module dffram_dp
  import dffram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 9,
  parameter int unsigned           CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE     = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN0,
  input  logic [DATA_WIDTH/8-1:0] WE0,
  input  logic [ADDR_WIDTH-1:0]   A0,
  input  logic [DATA_WIDTH-1:0]   Di0,
  output logic [DATA_WIDTH-1:0]   Do0,
  input  logic                    EN1,
  input  logic [ADDR_WIDTH-1:0]   A1,
  output logic [DATA_WIDTH-1:0]   Do1,
  input  logic                    CLR,
  output logic                    BUSY
);

  localparam int unsigned LANES = lane_count(DATA_WIDTH);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  if (!width_ok(DATA_WIDTH)) begin : g_width_check
    $error("dffram_dp: DATA_WIDTH must be a multiple of 8");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_do0;
  logic [DATA_WIDTH-1:0] r_do1;
  logic [DATA_WIDTH-1:0] w_do1_nxt;
  logic                  w_bypass;
  logic                  w_busy;
  logic                  w_fill_we;
  logic [ADDR_WIDTH-1:0] w_fill_addr;
  logic                  w_user_we;

  dffram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_clr       (CLR),
    .o_busy      (w_busy),
    .o_fill_addr (w_fill_addr),
    .o_fill_we   (w_fill_we)
  );

  assign w_user_we = EN0 && !w_busy && !RST;

  always_ff @(posedge CLK) begin
    if (w_fill_we) begin
      r_mem[w_fill_addr] <= FILL_VALUE;
    end else if (w_user_we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (WE0[i]) begin
          r_mem[A0][8*i +: 8] <= Di0[8*i +: 8];
        end
      end
    end
  end

  // Port 1 merges port 0's enabled write lanes so a vertex is readable in the cycle it is written.
  always_comb begin
    w_do1_nxt = r_mem[A1];
    w_bypass  = EN0 && (A0 == A1) && (|WE0);
    for (int unsigned i = 0; i < LANES; i++) begin
      if (w_bypass && WE0[i]) begin
        w_do1_nxt[8*i +: 8] = Di0[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || w_busy) begin
      r_do0 <= '0;
      r_do1 <= '0;
    end else begin
      r_do0 <= EN0 ? r_mem[A0] : '0;
      r_do1 <= EN1 ? w_do1_nxt : '0;
    end
  end

  assign Do0  = r_do0;
  assign Do1  = r_do1;
  assign BUSY = w_busy;

endmodule
